addsub_serial: RTL and testbench
================================

# addsub_serial

Parametrised, multi-cycle two's-complement adder/subtractor that processes a WIDTH-bit operand pair CHUNK bits per clock through a single ripple chunk adder. Operands are accepted and results are delivered over valid/ready handshakes. It raises carry/borrow and signed overflow flags and can optionally return the unsigned magnitude of a negative difference. It sits in the datapath wherever a full-width ripple subtractor is too large and a few cycles of latency are acceptable.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of CHUNK (elaboration error otherwise)
- CHUNK, 4, bits processed per cycle; NCH = WIDTH/CHUNK, NCH >= 1
- clk  in  1  rising-edge clock; the block uses this single clock only
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block idle, will accept
- op  in  1  0 = add (a+b), 1 = subtract (a-b)
- a  in  WIDTH  first operand
- b  in  WIDTH  second operand
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- result  out  WIDTH  sum/difference (magnitude when neg=1)
- carry  out  1  raw carry-out; for subtract 1 = no borrow (a >= b unsigned)
- ovf  out  1  signed overflow of the raw two's-complement result
- neg  out  1  result was converted to magnitude (ABS_EN only)

## Operation
- FSM states: IDLE, CALC, FIX, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
- IDLE: on in_valid, latch a, and b if op=0 or ~b if op=1. Set cin=op, idx=0, go to CALC.
- CALC: each cycle, chunk idx = a_chunk + b_chunk + cin. Write it into result[idx*CHUNK +: CHUNK], cin <= chunk carry-out, idx++.
- CALC on the last chunk (idx=NCH-1): carry <= carry-out; ovf <= carry into MSB XOR carry-out.
- CALC exit: if ABS_EN, op=1 and carry=0, go to FIX with idx=0, cin=1, neg<=1. Otherwise go to DONE.
- FIX: each cycle, chunk idx = ~result_chunk + cin (two's-complement negate, chunk-serial). After NCH cycles, go to DONE.
- carry and ovf always describe the raw result. FIX does not alter them.
- DONE: hold result/carry/ovf/neg stable until out_ready. On out_ready, go to IDLE. No new operand is accepted before IDLE.
- Arithmetic is modulo 2^WIDTH. The magnitude of a-b with a<b always fits WIDTH unsigned bits.
- Async reset, including mid-operation: abort immediately; no result is produced for the aborted op.

## Timing
- Accept in cycle T (in_valid && in_ready). CALC occupies T+1..T+NCH. out_valid rises at T+NCH+1.
- With FIX: out_valid rises at T+2*NCH+1.
- Back-to-back throughput: one op per NCH+2 cycles when out_ready is held high.
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, carry 0, ovf 0, neg 0, idx 0.
- The output handshake completes on the cycle out_valid && out_ready. in_ready is 1 the next cycle.

## Configuration
- ADDSUB_SERIAL_ABS_EN defined: FIX state present; a negative subtract returns |a-b| with neg=1.
- ADDSUB_SERIAL_ABS_EN undefined: FIX state absent; result is the raw two's-complement value; neg is tied 0.

## Structure
- Package addsub_pkg: state enum (IDLE, CALC, FIX, DONE) and op encoding constants (OP_ADD=0, OP_SUB=1).
- Sub-module chunk_adder: combinational CHUNK-bit ripple of full adders. Outputs sum, carry-out, and carry into the top bit (needed for ovf).
- Top module holds the FSM, operand/result registers and the chunk index counter. One chunk_adder instance is shared by CALC and FIX.

## Test plan
- WIDTH=16, CHUNK=4, add 0x1234+0x0FFF -> result 0x2233, carry 0, ovf 0, out_valid at T+5.
- Sub 0x0005-0x0003 -> 0x0002, carry 1, ovf 0, neg 0, out_valid at T+5.
- Sub 0x0003-0x0005 -> without macro: 0xFFFE, carry 0, neg 0, T+5. With macro: 0x0002, carry 0, neg 1, T+9.
- Overflow: add 0x7FFF+0x0001 -> 0x8000, ovf 1, carry 0. Sub 0x8000-0x0001 -> 0x7FFF, ovf 1, carry 1.
- Backpressure: hold out_ready low 3 cycles after out_valid -> outputs stable, in_ready 0. Raise out_ready -> in_ready 1 the next cycle; next op accepted.
- Assert rst_n low during CALC (idx=2) -> out_valid 0, in_ready 1 and all flags 0 immediately. A fresh op after release yields the correct result.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types for the chunk-serial add/subtract datapath.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Chunk index width; a single-chunk configuration still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple of full adders, shared by the add/subtract and negate passes.
// Latency: purely combinational.
// Backpressure: none; the caller sequences chunks.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]  = x[i] ^ y[i] ^ c[i];
        assign c[i+1]  = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
    end

    assign cout = c[CHUNK];
    // Carry into the top bit; XOR with cout gives signed overflow on the last chunk.
    assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/addsub_serial.sv
// Chunk-serial two's-complement add/subtract with carry/ovf flags; ADDSUB_SERIAL_ABS_EN adds |a-b| output.
// Latency: NCH+1 cycles from accept to out_valid (2*NCH+1 when a negative difference is negated).
// Backpressure: in_ready only in IDLE; result/flags held stable in DONE until out_ready.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf,
    output logic             neg
);

    localparam int NCH   = WIDTH / CHUNK;
    localparam int IDX_W = int'(idx_width(NCH));
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

    if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_cfg_err
        $error("addsub_serial: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, res_q;
    logic             cin_q, carry_q, ovf_q;
    logic [IDX_W-1:0] idx_q;

    logic [CHUNK-1:0] cx, cy, csum;
    logic             cout, cmsb;
    logic             last;
    logic             fix_go;

    assign last = (idx_q == LAST_IDX);

`ifdef ADDSUB_SERIAL_ABS_EN
    logic op_q, neg_q;
    // Negative difference: subtract that produced a borrow on the final chunk.
    assign fix_go = op_q & ~cout;
    assign neg    = neg_q;
`else
    assign fix_go = 1'b0;
    assign neg    = 1'b0;
`endif

    // Chunk operand select: operands during CALC, inverted result (+cin) during FIX.
    always_comb begin
        cx = a_q[idx_q*CHUNK +: CHUNK];
        cy = b_q[idx_q*CHUNK +: CHUNK];
        if (state_q == FIX) begin
            cx = ~res_q[idx_q*CHUNK +: CHUNK];
            cy = '0;
        end
    end

    chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
        .x    (cx),
        .y    (cy),
        .cin  (cin_q),
        .sum  (csum),
        .cout (cout),
        .cmsb (cmsb)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid)  state_d = CALC;
            CALC: if (last)      state_d = fix_go ? FIX : DONE;
            FIX:  if (last)      state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Operand capture, chunk write-back, carry chain and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
`ifdef ADDSUB_SERIAL_ABS_EN
            op_q    <= 1'b0;
            neg_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        // Subtract as a + ~b + 1; the +1 enters as the first carry-in.
                        b_q   <= (op == OP_SUB) ? ~b : b;
                        cin_q <= op;
                        idx_q <= '0;
`ifdef ADDSUB_SERIAL_ABS_EN
                        op_q  <= op;
                        neg_q <= 1'b0;
`endif
                    end
                end
                CALC: begin
                    res_q[idx_q*CHUNK +: CHUNK] <= csum;
                    cin_q <= cout;
                    idx_q <= idx_q + 1'b1;
                    if (last) begin
                        carry_q <= cout;
                        ovf_q   <= cmsb ^ cout;
                        idx_q   <= '0;
`ifdef ADDSUB_SERIAL_ABS_EN
                        if (fix_go) begin
                            cin_q <= 1'b1;
                            neg_q <= 1'b1;
                        end
`endif
                    end
                end
`ifdef ADDSUB_SERIAL_ABS_EN
                FIX: begin
                    res_q[idx_q*CHUNK +: CHUNK] <= csum;
                    cin_q <= cout;
                    idx_q <= last ? '0 : idx_q + 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign result = res_q;
    assign carry  = carry_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Randomised and directed check of addsub_serial against an arithmetic reference model.
// Latency: checks NCH+1 / 2*NCH+1 accept-to-valid and NCH+2 back-to-back spacing.
// Backpressure: holds out_ready low for random spans and checks outputs stay put.
module tb_addsub_serial;

    localparam int W   = 16;
    localparam int CH  = 4;
    localparam int NCH = W / CH;
`ifdef ADDSUB_SERIAL_ABS_EN
    localparam bit ABS = 1'b1;
`else
    localparam bit ABS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         op = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry, ovf, neg;

    addsub_serial #(.WIDTH(W), .CHUNK(CH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .ovf       (ovf),
        .neg       (neg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int last_drv = 0;
    bit prev_fast = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide arithmetic and sign rules.
    task automatic model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic c, output logic v,
                         output logic n, output int lat);
        logic [W:0] full;
        if (o == 1'b0) full = {1'b0, x} + {1'b0, y};
        else           full = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        r = full[W-1:0];
        c = full[W];
        if (o == 1'b0) v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        else           v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        n   = 1'b0;
        lat = NCH + 1;
        if (ABS && o && (x < y)) begin
            r   = y - x;
            n   = 1'b1;
            lat = 2 * NCH + 1;
        end
    endtask

    // Issue one operation from a negedge in IDLE, check result, latency and backpressure.
    task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int hold, input string tag);
        logic [W-1:0] er;
        logic         ec, ev, en;
        int           elat, k;
        logic [W-1:0] r0;
        model(o, x, y, er, ec, ev, en, elat);
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        if (prev_fast) check({tag, "_spacing"}, 32'(cyc - last_drv), 32'(NCH + 2));
        last_drv = cyc;
        in_valid = 1'b1;
        op = o;
        a  = x;
        b  = y;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a  = W'($urandom);
        b  = W'($urandom);
        op = 1'($urandom);
        k = 1;
        while (!out_valid && k < 4 * NCH + 10) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            prev_fast = 1'b0;
            return;
        end
        check({tag, "_lat"},    32'(k),      32'(elat));
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_carry"},  32'(carry),  32'(ec));
        check({tag, "_ovf"},    32'(ovf),    32'(ev));
        check({tag, "_neg"},    32'(neg),    32'(en));
        r0 = result;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"},  32'(out_valid), 32'd1);
            check({tag, "_hold_ready"},  32'(in_ready),  32'd0);
            check({tag, "_hold_result"}, 32'(result),    32'(r0));
            check({tag, "_hold_flags"},  32'({carry, ovf, neg}), 32'({ec, ev, en}));
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_post_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_post_out_valid"}, 32'(out_valid), 32'd0);
        prev_fast = (hold == 0) && (elat == NCH + 1);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result",    32'(result),    32'd0);
        check("rst_flags",     32'({carry, ovf, neg}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1'b0, 16'h1234, 16'h0FFF, 0, "add_1234_0fff");
        run_op(1'b1, 16'h0005, 16'h0003, 0, "sub_5_3");
        run_op(1'b1, 16'h0003, 16'h0005, 3, "sub_3_5_bp");
        run_op(1'b0, 16'h7FFF, 16'h0001, 0, "add_ovf");
        run_op(1'b1, 16'h8000, 16'h0001, 0, "sub_ovf");
        run_op(1'b1, 16'h0000, 16'hFFFF, 0, "sub_0_ffff");
        run_op(1'b0, 16'hFFFF, 16'hFFFF, 1, "add_ffff_ffff");

        // Abort mid-CALC: flags from sub_ovf (carry/ovf set) must clear on reset.
        run_op(1'b1, 16'h8000, 16'h0001, 0, "pre_abort");
        in_valid = 1'b1;
        op = 1'b0;
        a  = 16'h1111;
        b  = 16'h2222;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready",  32'(in_ready),  32'd1);
        check("abort_flags",     32'({carry, ovf, neg}), 32'd0);
        check("abort_result",    32'(result),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_fast = 1'b0;
        for (int i = 0; i < NCH + 3; i++) begin
            @(negedge clk);
            check("abort_no_result", 32'(out_valid), 32'd0);
        end
        run_op(1'b0, 16'h1111, 16'h2222, 0, "after_abort");

        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] x, y;
            logic         o;
            int           sel;
            sel = $urandom_range(0, 3);
            x = W'($urandom);
            y = W'($urandom);
            if (sel == 0) y = x;
            if (sel == 1) x = {x[W-1], {(W-1){~x[W-1]}}};
            o = 1'($urandom);
            run_op(o, x, y, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
